// File: rtl/seg_scan_capture.sv
// seg_scan_capture: rebuilds the 8 BCD digits shown on a multiplexed,
// active-low seven-segment scan (anode / LED_seg). Each digit is captured
// once its {anode, LED_seg} pair has been stable for SETTLE_CYCLES
// registered samples. A frame is committed as a whole once all eight
// digits have been captured.
// Optional build macro: SEG_CAPTURE_HEX_EN adds decoding of the hex
// glyphs A..F.
module seg_scan_capture #(
   parameter int SETTLE_CYCLES = 16,
   parameter int STALE_CYCLES  = 2000000
) (
   input  logic        CLK100MHZ,
   input  logic        reset,
   input  logic [7:0]  anode,
   input  logic [6:0]  LED_seg,
   output logic [31:0] digits,
   output logic [7:0]  blank_mask,
   output logic        frame_done,
   output logic        seg_error,
   output logic        scan_stale
);

   localparam int STALE_W = $clog2(STALE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

   // Returns {blank, error, code} for one active-low abcdefg pattern.
   function automatic logic [5:0] decode(input logic [6:0] seg);
      logic [5:0] r;
      case (seg)
         7'b0000001: r = {2'b00, 4'h0};
         7'b1001111: r = {2'b00, 4'h1};
         7'b0010010: r = {2'b00, 4'h2};
         7'b0000110: r = {2'b00, 4'h3};
         7'b1001100: r = {2'b00, 4'h4};
         7'b0100100: r = {2'b00, 4'h5};
         7'b0100000: r = {2'b00, 4'h6};
         7'b0001111: r = {2'b00, 4'h7};
         7'b0000000: r = {2'b00, 4'h8};
         7'b0000100: r = {2'b00, 4'h9};
`ifdef SEG_CAPTURE_HEX_EN
         7'b0001000: r = {2'b00, 4'hA};
         7'b1100000: r = {2'b00, 4'hB};
         7'b0110001: r = {2'b00, 4'hC};
         7'b1000010: r = {2'b00, 4'hD};
         7'b0110000: r = {2'b00, 4'hE};
         7'b0111000: r = {2'b00, 4'hF};
`endif
         7'b1111111: r = {2'b10, 4'hF};
         default:    r = {2'b01, 4'hE};
      endcase
      return r;
   endfunction

   logic [7:0]         anode_p0, anode_p1;
   logic [6:0]         seg_p0, seg_p1;
   state_t             state, state_nx;
   logic [7:0]         cnt, cnt_nx;
   logic               capture;
   logic [7:0]         lit;
   logic               valid, same;
   logic [2:0]         idx;
   logic [5:0]         dec;
   logic [31:0]        shadow;
   logic [7:0]         shadow_blank, shadow_err, mask, mask_cap;
   logic               commit_pend;
   logic [STALE_W-1:0] stale_cnt;

   assign lit      = ~anode_p0;
   assign valid    = (lit != 8'd0) && ((lit & (lit - 8'd1)) == 8'd0);
   assign same     = (anode_p0 == anode_p1) && (seg_p0 == seg_p1);
   assign dec      = decode(seg_p0);
   assign mask_cap = mask | (8'd1 << idx);

   // Active digit index from the one-hot-low registered anode.
   always_comb begin
      idx = 3'd0;
      for (int i = 0; i < 8; i++)
         if (lit[i]) idx = 3'(i);
   end

   // Input stage: register the scan once and keep the previous sample.
   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         anode_p0 <= 8'hFF;
         seg_p0   <= 7'h7F;
         anode_p1 <= 8'hFF;
         seg_p1   <= 7'h7F;
      end else begin
         anode_p0 <= anode;
         seg_p0   <= LED_seg;
         anode_p1 <= anode_p0;
         seg_p1   <= seg_p0;
      end
   end

   // Settle FSM state and stability counter.
   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 8'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next state: count identical samples, capture once when settled.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      capture  = 1'b0;
      case (state)
         IDLE: begin
            if (valid) begin
               state_nx = SETTLE;
               cnt_nx   = 8'd1;
            end
         end
         SETTLE: begin
            if (!valid) begin
               state_nx = IDLE;
               cnt_nx   = 8'd0;
            end else if (!same) begin
               cnt_nx = 8'd1;
            end else begin
               cnt_nx = cnt + 8'd1;
               if (cnt_nx == 8'(SETTLE_CYCLES)) begin
                  capture  = 1'b1;
                  state_nx = HELD;
               end
            end
         end
         HELD: begin
            if (!same) begin
               state_nx = valid ? SETTLE : IDLE;
               cnt_nx   = valid ? 8'd1 : 8'd0;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = 8'd0;
         end
      endcase
   end

   // Shadow frame capture and frame-atomic commit one cycle after completion.
   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         shadow       <= 32'd0;
         shadow_blank <= 8'd0;
         shadow_err   <= 8'd0;
         mask         <= 8'd0;
         commit_pend  <= 1'b0;
         digits       <= 32'd0;
         blank_mask   <= 8'hFF;
         seg_error    <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         frame_done  <= commit_pend;
         commit_pend <= 1'b0;
         if (commit_pend) begin
            digits     <= shadow;
            blank_mask <= shadow_blank;
            seg_error  <= |shadow_err;
         end
         if (capture) begin
            shadow[{idx, 2'b00} +: 4] <= dec[3:0];
            shadow_blank[idx]         <= dec[5];
            shadow_err[idx]           <= dec[4];
            if (mask_cap == 8'hFF) begin
               mask        <= 8'd0;
               commit_pend <= 1'b1;
            end else begin
               mask <= mask_cap;
            end
         end
      end
   end

   // Cycles since the last capture, saturating at the stale threshold.
   always_ff @(posedge CLK100MHZ) begin
      if (reset || capture)
         stale_cnt <= '0;
      else if (stale_cnt < STALE_W'(STALE_CYCLES))
         stale_cnt <= stale_cnt + 1'b1;
   end

   assign scan_stale = (stale_cnt >= STALE_W'(STALE_CYCLES));

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: a sample-level model of the scan rules is
// compared with the DUT outputs every cycle, and directed scenarios pin
// literal expected values.
module tb_seg_scan_capture;

   localparam int S     = 16;
   localparam int STALE = 1000;
   localparam int DW    = 40;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  anode;
   logic [6:0]  LED_seg;
   logic [31:0] digits;
   logic [7:0]  blank_mask;
   logic        frame_done, seg_error, scan_stale;

   seg_scan_capture #(.SETTLE_CYCLES(S), .STALE_CYCLES(STALE)) dut (
      .CLK100MHZ(clk), .reset(reset), .anode(anode), .LED_seg(LED_seg),
      .digits(digits), .blank_mask(blank_mask), .frame_done(frame_done),
      .seg_error(seg_error), .scan_stale(scan_stale));

   always #5 clk = ~clk;

   // Glyph table, entry k = active-low abcdefg pattern of hex value k.
   logic [6:0] pat [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
`ifdef SEG_CAPTURE_HEX_EN
   localparam int NPAT = 16;
`else
   localparam int NPAT = 10;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int pulses = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          model_on = 0;
   logic [7:0]  last_a;
   logic [6:0]  last_s;
   int          run;
   bit          cap_pend, commit_pend;
   int          cap_idx;
   logic [6:0]  cap_seg;
   logic [31:0] sh, snap_d, m_dig;
   logic [7:0]  shb, she, msk, snap_b, m_blank;
   bit          snap_e, m_err, m_fd;
   int          m_stale;

   function automatic logic [5:0] m_decode(input logic [6:0] s);
      if (s == 7'h7F) return {2'b10, 4'hF};
      for (int k = 0; k < NPAT; k++)
         if (pat[k] == s) return {2'b00, 4'(k)};
      return {2'b01, 4'hE};
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            model_on = 1; last_a = 8'hFF; last_s = 7'h7F; run = 0;
            cap_pend = 0; commit_pend = 0; sh = 0; shb = 0; she = 0; msk = 0;
            m_dig = 0; m_blank = 8'hFF; m_err = 0; m_fd = 0; m_stale = 0;
         end else begin
            logic [5:0] d;
            m_fd = 0;
            if (commit_pend) begin
               m_dig = snap_d; m_blank = snap_b; m_err = snap_e; m_fd = 1;
               commit_pend = 0;
            end
            if (cap_pend) begin
               d = m_decode(cap_seg);
               sh[cap_idx*4 +: 4] = d[3:0];
               shb[cap_idx] = d[5];
               she[cap_idx] = d[4];
               msk[cap_idx] = 1'b1;
               if (msk == 8'hFF) begin
                  snap_d = sh; snap_b = shb; snap_e = |she;
                  commit_pend = 1; msk = 0;
               end
               m_stale = 0;
               cap_pend = 0;
            end else if (m_stale < STALE) begin
               m_stale++;
            end
            if (anode == last_a && LED_seg == last_s) run++;
            else run = 1;
            last_a = anode; last_s = LED_seg;
            if ($countones(~anode) == 1 && run == S) begin
               cap_pend = 1; cap_seg = LED_seg;
               for (int i = 0; i < 8; i++) if (!anode[i]) cap_idx = i;
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (model_on) begin
            chk("cycle", {21'd0, digits, blank_mask, frame_done, seg_error, scan_stale},
                {21'd0, m_dig, m_blank, m_fd, m_err, (m_stale >= STALE)});
            if (frame_done === 1'b1) pulses++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic show(input int d, input logic [6:0] seg, input int cycles);
      anode = ~(8'd1 << d);
      LED_seg = seg;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic frame(input logic [31:0] v, input int dwell);
      for (int i = 0; i < 8; i++) show(i, pat[v[i*4 +: 4]], dwell);
   endtask

   int p;
   logic [31:0] v;

   initial begin
      reset = 1'b1; anode = 8'hFF; LED_seg = 7'h7F;
      repeat (3) @(negedge clk);
      chk("rst_digits", 64'(digits), 64'h0);
      chk("rst_blank", 64'(blank_mask), 64'hFF);
      chk("rst_flags", 64'({frame_done, seg_error, scan_stale}), 64'h0);
      reset = 1'b0;

      // Basic frame.
      p = pulses;
      frame(32'h95432100, 100);
      repeat (4) @(negedge clk);
      chk("t1_digits", 64'(digits), 64'h95432100);
      chk("t1_blank", 64'(blank_mask), 64'h00);
      chk("t1_err", 64'(seg_error), 64'h0);
      chk("t1_pulses", 64'(pulses - p), 64'd1);

      // Digit 3 one sample short: no commit until it is shown long enough.
      p = pulses;
      v = 32'h76543210;
      for (int i = 0; i < 8; i++) show(i, pat[v[i*4 +: 4]], (i == 3) ? S - 1 : DW);
      chk("t2_nocommit", 64'(pulses - p), 64'd0);
      chk("t2_old", 64'(digits), 64'h95432100);
      show(3, pat[3], DW);
      chk("t2_pulses", 64'(pulses - p), 64'd1);
      chk("t2_digits", 64'(digits), 64'h76543210);

      // Invalid two-digit anode mid-scan.
      p = pulses;
      v = 32'h13572468;
      for (int i = 0; i < 4; i++) show(i, pat[v[i*4 +: 4]], DW);
      anode = 8'b11110011; LED_seg = pat[5];
      repeat (500) @(negedge clk);
      chk("t3_idle", 64'(pulses - p), 64'd0);
      for (int i = 4; i < 8; i++) show(i, pat[v[i*4 +: 4]], DW);
      chk("t3_pulses", 64'(pulses - p), 64'd1);
      chk("t3_digits", 64'(digits), 64'h13572468);

      // Blank, undecodable and hex glyphs.
      show(0, pat[1], DW); show(1, pat[2], DW); show(2, pat[3], DW);
      show(3, pat[4], DW); show(4, pat[10], DW); show(5, 7'b1111111, DW);
      show(6, 7'b0110110, DW); show(7, pat[8], DW);
`ifdef SEG_CAPTURE_HEX_EN
      chk("t4_digits", 64'(digits), 64'h8EFA4321);
`else
      chk("t4_digits", 64'(digits), 64'h8EFE4321);
`endif
      chk("t4_blank", 64'(blank_mask), 64'h20);
      chk("t4_err", 64'(seg_error), 64'h1);
      frame(32'h24681357, DW);
      chk("t4_clean_err", 64'(seg_error), 64'h0);
      chk("t4_clean_blank", 64'(blank_mask), 64'h00);

      // Scan halted long enough to go stale, then resumed.
      anode = 8'hFF; LED_seg = 7'h7F;
      repeat (STALE + 10) @(negedge clk);
      chk("t5_stale", 64'(scan_stale), 64'h1);
      chk("t5_hold", 64'(digits), 64'h24681357);
      anode = 8'b11111110; LED_seg = pat[4];
      repeat (S) @(negedge clk);
      chk("t5_still_stale", 64'(scan_stale), 64'h1);
      @(negedge clk);
      chk("t5_unstale", 64'(scan_stale), 64'h0);
      repeat (DW - S - 1) @(negedge clk);
      v = 32'h11223344;
      for (int i = 1; i < 8; i++) show(i, pat[v[i*4 +: 4]], DW);
      chk("t5_digits", 64'(digits), 64'h11223344);

      // Reset after a partial frame.
      for (int i = 0; i < 5; i++) show(i, pat[9], DW);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("t6_rst_digits", 64'(digits), 64'h0);
      chk("t6_rst_blank", 64'(blank_mask), 64'hFF);
      p = pulses;
      v = 32'h87654321;
      for (int i = 0; i < 7; i++) show(i, pat[v[i*4 +: 4]], DW);
      chk("t6_partial", 64'(digits), 64'h0);
      show(7, pat[8], DW);
      chk("t6_digits", 64'(digits), 64'h87654321);
      chk("t6_blank", 64'(blank_mask), 64'h00);
      chk("t6_pulses", 64'(pulses - p), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
